rtc_tick_gen: RTL and testbench

Fractional-N real-time-clock generator for the SoC timer subsystem. It derives a nominally 32.768 kHz square wave from `HCLK` using a phase accumulator and drives it on `rtc_o`, which feeds the `rtc_i` input of the machine timer directly. Software programs frequency and enable over the same 64-bit APB slave style used by the timer. Frequency updates are glitch-free because they apply only at an accumulator wrap.

---
 rtl/rtc_tick_gen_if.sv | 24 ++
 rtl/rtc_tick_gen.sv | 199 +++++++++++++++++++
 tb/tb_rtc_tick_gen.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_tick_gen_if.sv
// APB-style register bus between a master and the rtc_tick_gen register file.
// Signal names follow the SoC APB naming so the timer subsystem can share the wiring.
interface rtc_tick_gen_if #(
  parameter int APB_ADDR_WIDTH = 12
);
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [63:0]               PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [63:0]               PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/rtc_tick_gen.sv
// Fractional-N RTC square-wave generator built on a phase accumulator; increment changes apply only at a wrap.
// Optional feature macro RTC_TICK_GEN_TICK_COUNT_EN adds a 32-bit rising-edge counter at register 3.
module rtc_tick_gen #(
  parameter int                   APB_ADDR_WIDTH = 12,
  parameter int                   ACC_WIDTH      = 32,
  parameter logic [ACC_WIDTH-1:0] RESET_INCR     = 32'h002A_F31E
) (
  input  logic          HCLK,
  input  logic          HRESET,
  rtc_tick_gen_if.slave apb,
  output logic          rtc_o
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_INCR   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_TICKS  = 2'd3;

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] incr_act_q, incr_act_d;
  logic [ACC_WIDTH-1:0] incr_shd_q, incr_shd_d;
  logic                 rtc_q, rtc_d;

  logic [APB_ADDR_WIDTH-1:0] paddr_s;
  logic [1:0]                reg_sel_s;
  logic                      access_s, wr_s, rd_s;
  logic                      incr_bad_s, incr_wr_s, ctrl_wr_s;
  logic                      pend_s;
  logic [ACC_WIDTH:0]        sum_s;
  logic                      wrap_s;
  logic [63:0]               rdata_s;
  logic                      slverr_s;
  logic                      unused_ok_s;

  assign paddr_s     = apb.PADDR;
  assign reg_sel_s   = paddr_s[4:3];
  assign unused_ok_s = ^{paddr_s, apb.PWDATA};

  // Access decode and the shared adder whose carry-out marks the wrap
  always_comb begin
    access_s   = apb.PSEL && apb.PENABLE;
    wr_s       = access_s && apb.PWRITE;
    rd_s       = access_s && !apb.PWRITE;
    incr_bad_s = |apb.PWDATA[ACC_WIDTH-1:ACC_WIDTH-4];
    incr_wr_s  = wr_s && (reg_sel_s == REG_INCR) && !incr_bad_s;
    ctrl_wr_s  = wr_s && (reg_sel_s == REG_CTRL);
    pend_s     = (incr_shd_q != incr_act_q);
    sum_s      = {1'b0, acc_q} + {1'b0, incr_act_q};
    wrap_s     = sum_s[ACC_WIDTH];
  end

  // Next-state logic: IDLE pins the accumulator, RUN accumulates and swaps increments at a wrap
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    incr_act_d = incr_act_q;
    incr_shd_d = incr_shd_q;
    rtc_d      = rtc_q;
    case (state_q)
      IDLE: begin
        acc_d = {ACC_WIDTH{1'b0}};
        rtc_d = 1'b0;
        if (incr_wr_s) begin
          incr_shd_d = apb.PWDATA[ACC_WIDTH-1:0];
          incr_act_d = apb.PWDATA[ACC_WIDTH-1:0];
        end else begin
          incr_shd_d = incr_shd_q;
          incr_act_d = incr_act_q;
        end
        if (ctrl_wr_s && apb.PWDATA[0]) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (ctrl_wr_s && !apb.PWDATA[0]) begin
          state_d    = IDLE;
          acc_d      = {ACC_WIDTH{1'b0}};
          rtc_d      = 1'b0;
          incr_act_d = incr_shd_q;
        end else begin
          state_d = RUN;
          if (ctrl_wr_s && apb.PWDATA[1]) begin
            acc_d = {ACC_WIDTH{1'b0}};
          end else begin
            acc_d = sum_s[ACC_WIDTH-1:0];
          end
          rtc_d = acc_d[ACC_WIDTH-1];
          // The wrap takes the shadow as it was before any same-cycle write
          if (wrap_s && pend_s) begin
            incr_act_d = incr_shd_q;
          end else begin
            incr_act_d = incr_act_q;
          end
          if (incr_wr_s) begin
            incr_shd_d = apb.PWDATA[ACC_WIDTH-1:0];
          end else begin
            incr_shd_d = incr_shd_q;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        acc_d      = {ACC_WIDTH{1'b0}};
        rtc_d      = 1'b0;
        incr_act_d = incr_shd_q;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= IDLE;
      acc_q      <= {ACC_WIDTH{1'b0}};
      incr_act_q <= RESET_INCR;
      incr_shd_q <= RESET_INCR;
      rtc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      incr_act_q <= incr_act_d;
      incr_shd_q <= incr_shd_d;
      rtc_q      <= rtc_d;
    end
  end

`ifdef RTC_TICK_GEN_TICK_COUNT_EN
  logic [31:0] ticks_q, ticks_d;

  // Rising-edge counter; a software load wins over a coincident increment
  always_comb begin
    ticks_d = ticks_q;
    if (wr_s && (reg_sel_s == REG_TICKS)) begin
      ticks_d = apb.PWDATA[31:0];
    end else if (rtc_d && !rtc_q) begin
      ticks_d = ticks_q + 32'd1;
    end else begin
      ticks_d = ticks_q;
    end
  end

  // Tick counter register
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ticks_q <= 32'd0;
    end else begin
      ticks_q <= ticks_d;
    end
  end
`endif

  // Read mux and error response, both combinational on the access phase
  always_comb begin
    rdata_s  = 64'd0;
    slverr_s = 1'b0;
    if (rd_s) begin
      case (reg_sel_s)
        REG_CTRL:   rdata_s[0] = (state_q == RUN);
        REG_INCR:   rdata_s[ACC_WIDTH-1:0] = incr_shd_q;
        REG_STATUS: rdata_s[1:0] = {pend_s, rtc_q};
`ifdef RTC_TICK_GEN_TICK_COUNT_EN
        REG_TICKS:  rdata_s[31:0] = ticks_q;
`else
        REG_TICKS:  rdata_s = 64'd0;
`endif
        default:    rdata_s = 64'd0;
      endcase
    end else begin
      rdata_s = 64'd0;
    end
    if (access_s) begin
      case (reg_sel_s)
        REG_INCR:  slverr_s = apb.PWRITE && incr_bad_s;
`ifdef RTC_TICK_GEN_TICK_COUNT_EN
        REG_TICKS: slverr_s = 1'b0;
`else
        REG_TICKS: slverr_s = 1'b1;
`endif
        default:   slverr_s = 1'b0;
      endcase
    end else begin
      slverr_s = 1'b0;
    end
  end

  assign apb.PRDATA  = rdata_s;
  assign apb.PSLVERR = slverr_s;
  assign apb.PREADY  = 1'b1;
  assign rtc_o       = rtc_q;

endmodule

// File: tb/tb_rtc_tick_gen.sv
// Scoreboard bench for rtc_tick_gen: expected APB responses and rtc_o edge times are queued
// by the stimulus and consumed by independent monitors.
module tb_rtc_tick_gen;
  localparam int AW = 12;
  localparam logic [11:0] A_CTRL   = 12'h000;
  localparam logic [11:0] A_INCR   = 12'h008;
  localparam logic [11:0] A_STATUS = 12'h010;
  localparam logic [11:0] A_TICKS  = 12'h018;

  logic HCLK   = 1'b0;
  logic HRESET = 1'b1;
  logic rtc_o;

  rtc_tick_gen_if #(.APB_ADDR_WIDTH(AW)) bus ();

  rtc_tick_gen #(
    .APB_ADDR_WIDTH(AW),
    .ACC_WIDTH     (32),
    .RESET_INCR    (32'h002A_F31E)
  ) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .apb   (bus),
    .rtc_o (rtc_o)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [63:0] rdata;
    logic        slverr;
  } apb_exp_t;

  typedef struct {
    string name;
    int    at;
    logic  lvl;
  } edge_exp_t;

  apb_exp_t  apb_q[$];
  edge_exp_t edge_q[$];
  int        n_cmp = 0;
  int        n_fail = 0;
  bit        mon_en = 1'b0;
  logic      rtc_prev = 1'b0;
  int        c0, c1, c2;

  // APB response monitor: every access phase consumes one expectation
  always @(negedge HCLK) begin
    apb_exp_t e;
    if (bus.PSEL && bus.PENABLE) begin
      n_cmp++;
      if (apb_q.size() == 0) begin
        n_fail++;
        $display("FAIL apb_unexpected: access at cycle %0d, none expected", cyc);
      end else begin
        e = apb_q.pop_front();
        if (bus.PRDATA !== e.rdata || bus.PSLVERR !== e.slverr || bus.PREADY !== 1'b1) begin
          n_fail++;
          $display("FAIL %s: got rdata=%h slverr=%b ready=%b, expected rdata=%h slverr=%b ready=1",
                   e.name, bus.PRDATA, bus.PSLVERR, bus.PREADY, e.rdata, e.slverr);
        end
      end
    end
  end

  // rtc_o edge monitor: every level change must match the next predicted edge
  always @(negedge HCLK) begin
    edge_exp_t e;
    if (mon_en && (rtc_o !== rtc_prev)) begin
      n_cmp++;
      if (edge_q.size() == 0) begin
        n_fail++;
        $display("FAIL rtc_unexpected: rtc_o became %b at cycle %0d, no edge expected", rtc_o, cyc);
      end else begin
        e = edge_q.pop_front();
        if (cyc != e.at || rtc_o !== e.lvl) begin
          n_fail++;
          $display("FAIL %s: rtc_o became %b at cycle %0d, expected %b at cycle %0d",
                   e.name, rtc_o, cyc, e.lvl, e.at);
        end
      end
    end
    rtc_prev = rtc_o;
  end

  task automatic apb_xfer(input logic wr, input logic [11:0] addr, input logic [63:0] wdata);
    @(posedge HCLK); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = addr; bus.PWDATA = wdata;
    @(posedge HCLK); #1;
    bus.PENABLE = 1'b1;
    @(posedge HCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic apb_wr(input string name, input logic [11:0] addr, input logic [63:0] wdata,
                        input logic exp_err);
    apb_exp_t e;
    e.name = name; e.rdata = 64'd0; e.slverr = exp_err;
    apb_q.push_back(e);
    apb_xfer(1'b1, addr, wdata);
  endtask

  task automatic apb_rd(input string name, input logic [11:0] addr, input logic [63:0] exp_data,
                        input logic exp_err);
    apb_exp_t e;
    e.name = name; e.rdata = exp_data; e.slverr = exp_err;
    apb_q.push_back(e);
    apb_xfer(1'b0, addr, 64'd0);
  endtask

  task automatic exp_edge(input string name, input int at, input logic lvl);
    edge_exp_t e;
    e.name = name; e.at = at; e.lvl = lvl;
    edge_q.push_back(e);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge HCLK);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = 12'h000; bus.PWDATA = 64'd0;
    HRESET = 1'b1;
    repeat (2) @(posedge HCLK);
    #1 HRESET = 1'b0;
    @(negedge HCLK);
    mon_en = 1'b1;
    n_cmp++;
    if (rtc_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rtc: rtc_o=%b, expected 0", rtc_o);
    end
    apb_rd("reset_ctrl",   A_CTRL,   64'd0,           1'b0);
    apb_rd("reset_incr",   A_INCR,   64'h002A_F31E,   1'b0);
    apb_rd("reset_status", A_STATUS, 64'd0,           1'b0);

    // Basic period at INCR = 2^27: 16 high / 16 low, first rise 16 cycles after EN
    apb_wr("wr_incr_idle", A_INCR, 64'h0800_0000, 1'b0);
    apb_rd("idle_no_pend", A_STATUS, 64'd0, 1'b0);
    apb_wr("wr_en", A_CTRL, 64'd1, 1'b0);
    c0 = cyc;
    exp_edge("rise1", c0 + 16, 1'b1);
    exp_edge("fall1", c0 + 32, 1'b0);
    exp_edge("rise2", c0 + 48, 1'b1);
    exp_edge("fall_wrap", c0 + 64, 1'b0);
    exp_edge("rise_slow", c0 + 96, 1'b1);
    exp_edge("fall_slow", c0 + 128, 1'b0);
    exp_edge("rise_slow2", c0 + 160, 1'b1);
    wait_until(c0 + 18);
    apb_rd("status_high", A_STATUS, 64'd1, 1'b0);
    apb_wr("illegal_incr", A_INCR, 64'h1000_0000, 1'b1);
    apb_rd("incr_kept", A_INCR, 64'h0800_0000, 1'b0);
    wait_until(c0 + 36);
    apb_rd("status_low", A_STATUS, 64'd0, 1'b0);

    // Glitch-free slow-down: shadow pends until the wrap at c0+64
    wait_until(c0 + 40);
    apb_wr("wr_incr_run", A_INCR, 64'h0400_0000, 1'b0);
    wait_until(c0 + 50);
    apb_rd("status_pend", A_STATUS, 64'd3, 1'b0);
    apb_rd("incr_shadow", A_INCR, 64'h0400_0000, 1'b0);
    wait_until(c0 + 70);
    apb_rd("status_swapped", A_STATUS, 64'd0, 1'b0);

    // Disable while high, restart, then CLR mid-run
    wait_until(c0 + 165);
    exp_edge("fall_disable", c0 + 168, 1'b0);
    apb_wr("wr_dis", A_CTRL, 64'd0, 1'b0);
    apb_rd("ctrl_off", A_CTRL, 64'd0, 1'b0);
    apb_wr("wr_en2", A_CTRL, 64'd1, 1'b0);
    c1 = cyc;
    exp_edge("rise_restart", c1 + 32, 1'b1);
    wait_until(c1 + 40);
    exp_edge("fall_clr", c1 + 43, 1'b0);
    exp_edge("rise_after_clr", c1 + 75, 1'b1);
    apb_wr("wr_en_clr", A_CTRL, 64'd3, 1'b0);
    apb_rd("ctrl_on", A_CTRL, 64'd1, 1'b0);

    // Synchronous reset while running and high
    wait_until(c1 + 80);
    exp_edge("fall_reset", c1 + 81, 1'b0);
    HRESET = 1'b1;
    @(negedge HCLK);
    HRESET = 1'b0;
    apb_rd("rst2_ctrl",   A_CTRL,   64'd0,         1'b0);
    apb_rd("rst2_incr",   A_INCR,   64'h002A_F31E, 1'b0);
    apb_rd("rst2_status", A_STATUS, 64'd0,         1'b0);

`ifdef RTC_TICK_GEN_TICK_COUNT_EN
    apb_rd("ticks_reset", A_TICKS, 64'd0, 1'b0);
    apb_wr("wr_incr_t", A_INCR, 64'h0800_0000, 1'b0);
    apb_wr("wr_en_t", A_CTRL, 64'd1, 1'b0);
    c2 = cyc;
    for (int k = 0; k < 6; k++) begin
      exp_edge("t_rise", c2 + 16 + 32 * k, 1'b1);
      if (k < 5) exp_edge("t_fall", c2 + 32 + 32 * k, 1'b0);
    end
    wait_until(c2 + 152);
    apb_rd("ticks_5", A_TICKS, 64'd5, 1'b0);
    apb_wr("wr_ticks", A_TICKS, 64'hFFFF_FFFF, 1'b0);
    wait_until(c2 + 180);
    apb_rd("ticks_wrap", A_TICKS, 64'd0, 1'b0);
    wait_until(c2 + 185);
    exp_edge("t_fall_dis", c2 + 188, 1'b0);
    apb_wr("wr_dis_t", A_CTRL, 64'd0, 1'b0);
`else
    apb_rd("ticks_absent_rd", A_TICKS, 64'd0, 1'b1);
    apb_wr("ticks_absent_wr", A_TICKS, 64'h1234, 1'b1);
    c2 = cyc;
`endif

    repeat (10) @(negedge HCLK);
    n_cmp++;
    if (apb_q.size() != 0) begin
      n_fail++;
      $display("FAIL apb_leftover: %0d expectations unconsumed, expected 0", apb_q.size());
    end
    n_cmp++;
    if (edge_q.size() != 0) begin
      n_fail++;
      $display("FAIL edge_leftover: %0d edges never seen, expected 0", edge_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
